// File: rtl/uart_stream_echo.sv
// uart_stream_echo: queues uart_rx bytes in a FIFO and replays them to uart_tx,
// either verbatim or upper-cased, or emits a periodic incrementing test pattern.
module uart_stream_echo #(
  parameter int         FIFO_DEPTH       = 16,
  parameter int         PATTERN_INTERVAL = 1000,
  parameter logic [7:0] PATTERN_START    = 8'h00
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic [1:0]                  i_Mode,
  input  logic                        i_Clear_Ovf,
  input  logic                        i_Rx_DV,
  input  logic [7:0]                  i_Rx_Byte,
  input  logic                        i_Tx_Done,
  output logic                        o_Tx_DV,
  output logic [7:0]                  o_Tx_Byte,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
  output logic                        o_Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(PATTERN_INTERVAL);
  localparam logic [AW:0]   FULL_COUNT    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   COUNT_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE       = AW'(1);
  localparam logic [IW-1:0] INTERVAL_LAST = IW'(PATTERN_INTERVAL - 1);
  localparam logic [IW-1:0] INTERVAL_ONE  = IW'(1);

  localparam logic [1:0] MODE_ECHO    = 2'd1;
  localparam logic [1:0] MODE_PATTERN = 2'd2;
  localparam logic [1:0] MODE_UPPER   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wrPtr_q, rdPtr_q;
  logic [AW:0]     count_q, count_d;
  logic [IW-1:0]   intervalCnt_q, intervalCnt_d;
  logic [7:0]      patByte_q, patByte_d;
  logic [7:0]      txByte_q, txByte_d;
  logic            overflow_q, overflow_d;

  logic            rxPush, patPush, pushReq, pop, accept, drop;
  logic [7:0]      rxData, pushData;

  // A push into a full FIFO still fits when the head leaves on the same edge.
  always_comb begin
    rxData = i_Rx_Byte;
    if (i_Mode == MODE_UPPER && i_Rx_Byte >= 8'h61 && i_Rx_Byte <= 8'h7A)
      rxData = i_Rx_Byte - 8'h20;
    rxPush   = i_Rx_DV && (i_Mode == MODE_ECHO || i_Mode == MODE_UPPER);
    patPush  = (i_Mode == MODE_PATTERN) && (intervalCnt_q == INTERVAL_LAST);
    pushReq  = rxPush || patPush;
    pushData = patPush ? patByte_q : rxData;
    pop      = (state_q == S_IDLE) && (count_q != '0);
    accept   = pushReq && ((count_q != FULL_COUNT) || pop);
    drop     = pushReq && !accept;
  end

  always_comb begin
    state_d  = state_q;
    txByte_d = txByte_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          txByte_d = mem_q[rdPtr_q];
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_BUSY;
      S_BUSY: begin
        if (i_Tx_Done)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (accept && !pop)
      count_d = count_q + COUNT_ONE;
    else if (!accept && pop)
      count_d = count_q - COUNT_ONE;

    intervalCnt_d = '0;
    if (i_Mode == MODE_PATTERN && intervalCnt_q != INTERVAL_LAST)
      intervalCnt_d = intervalCnt_q + INTERVAL_ONE;

    // A dropped pattern byte keeps its value so the next interval retries it.
    patByte_d = patByte_q;
    if (patPush && accept)
      patByte_d = patByte_q + 8'd1;

    overflow_d = overflow_q;
    if (drop)
      overflow_d = 1'b1;
    else if (i_Clear_Ovf)
      overflow_d = 1'b0;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q       <= S_IDLE;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      intervalCnt_q <= '0;
      patByte_q     <= PATTERN_START;
      txByte_q      <= 8'h00;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      intervalCnt_q <= intervalCnt_d;
      patByte_q     <= patByte_d;
      txByte_q      <= txByte_d;
      overflow_q    <= overflow_d;
      if (accept)
        wrPtr_q <= wrPtr_q + PTR_ONE;
      if (pop)
        rdPtr_q <= rdPtr_q + PTR_ONE;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (accept)
      mem_q[wrPtr_q] <= pushData;
  end

  assign o_Tx_DV      = (state_q == S_LAUNCH);
  assign o_Tx_Byte    = txByte_q;
  assign o_Fifo_Count = count_q;
  assign o_Overflow   = overflow_q;

endmodule
